lsu: RTL and testbench

Load/store unit for the single-cycle RV32I core, directly downstream of the ALU: it takes the ALU result as the effective address and runs one data-memory transaction per load or store over a req/ack handshake. It generates byte enables and lane-replicated store data, and returns sign- or zero-extended load data. While a transaction is outstanding it stalls the core via `o_busy`.

---
 rtl/lsu_if.sv | 35 +++
 rtl/lsu.sv | 158 +++++++++++++++
 tb/tb_lsu.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Core-side and memory-side signals of the load/store unit, bundled so the
// LSU and its environment connect through a single port.
interface lsu_if;
    logic        i_valid;
    logic        i_ld_en;
    logic        i_st_en;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_ld_data;
    logic [1:0]  o_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [29:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_valid, i_ld_en, i_st_en, i_funct3, i_addr, i_st_data,
        input  i_mem_ack, i_mem_rdata,
        output o_busy, o_done, o_ld_data, o_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );

    modport master (
        output i_valid, i_ld_en, i_st_en, i_funct3, i_addr, i_st_data,
        output i_mem_ack, i_mem_rdata,
        input  o_busy, o_done, o_ld_data, o_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one req/ack data-memory transaction per load or store,
// with byte-lane steering, load extension, alignment/legality checks and a bus timeout.
module lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic  i_clk,
    input logic  i_rst,
    lsu_if.slave bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               done_q, req_q, we_q;
    logic [1:0]         err_q, err_next;
    logic [31:0]        ld_data_q, ld_data_next;
    logic [29:0]        addr_q;
    logic [3:0]         be_q, be_calc;
    logic [31:0]        wdata_q, wdata_calc, ld_ext;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic               single_op, both_op, legal, misaligned, capture;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;

    assign single_op = bus.i_valid && (bus.i_ld_en ^ bus.i_st_en);
    assign both_op   = bus.i_valid && bus.i_ld_en && bus.i_st_en;

    // Decode of the incoming request, evaluated only in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        legal      = 1'b0;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = bus.i_st_data;
        unique case (bus.i_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = bus.i_ld_en;
            default:                legal = 1'b0;
        endcase
        unique case (bus.i_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << bus.i_addr[1:0];
                wdata_calc = {4{bus.i_st_data[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << bus.i_addr[1:0];
                wdata_calc = {2{bus.i_st_data[15:0]}};
                misaligned = bus.i_addr[0];
            end
            default: misaligned = (bus.i_addr[1:0] != 2'b00);
        endcase
    end

    // Lane select and extension of the returned word, using the captured offset.
    always_comb begin
        lane_b = bus.i_mem_rdata[8*off_q +: 8];
        lane_h = bus.i_mem_rdata[16*off_q[1] +: 16];
        unique case (f3_q)
            3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  ld_ext = {24'h0, lane_b};
            3'b101:  ld_ext = {16'h0, lane_h};
            default: ld_ext = bus.i_mem_rdata;
        endcase
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        err_next     = err_q;
        ld_data_next = ld_data_q;
        capture      = 1'b0;
        unique case (state)
            IDLE: begin
                if (single_op) begin
                    capture      = 1'b1;
                    cnt_next     = '0;
                    ld_data_next = 32'h0;
                    if (!legal) begin
                        state_next = DONE;
                        err_next   = 2'b10;
                    end else if (misaligned) begin
                        state_next = DONE;
                        err_next   = 2'b01;
                    end else begin
                        state_next = REQ;
                    end
                end else if (both_op) begin
                    state_next   = DONE;
                    err_next     = 2'b10;
                    ld_data_next = 32'h0;
                end
            end
            REQ: begin
                cnt_next = cnt + CNT_W'(1);
                // Ack is checked first so it wins over a same-cycle timeout.
                if (bus.i_mem_ack) begin
                    state_next   = DONE;
                    err_next     = 2'b00;
                    ld_data_next = we_q ? 32'h0 : ld_ext;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    state_next   = DONE;
                    err_next     = 2'b11;
                    ld_data_next = 32'h0;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            err_q     <= 2'b00;
            ld_data_q <= 32'h0;
            we_q      <= 1'b0;
            addr_q    <= 30'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            done_q    <= (state_next == DONE);
            req_q     <= (state_next == REQ);
            err_q     <= err_next;
            ld_data_q <= ld_data_next;
            if (capture) begin
                we_q    <= bus.i_st_en;
                addr_q  <= bus.i_addr[31:2];
                be_q    <= be_calc;
                wdata_q <= wdata_calc;
                f3_q    <= bus.i_funct3;
                off_q   <= bus.i_addr[1:0];
            end
        end
    end

    assign bus.o_busy      = (state == REQ) || (state == IDLE && (single_op || both_op));
    assign bus.o_done      = done_q;
    assign bus.o_ld_data   = ld_data_q;
    assign bus.o_err       = err_q;
    assign bus.o_mem_req   = req_q;
    assign bus.o_mem_we    = we_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_be    = be_q;
    assign bus.o_mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a scoreboard queue of expected completions,
// a small word-addressed memory model and per-scenario tasks.
module tb_lsu;
    logic clk;
    logic rst;
    lsu_if bus ();

    lsu #(.TIMEOUT(16)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  err;
        logic [31:0] ld;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem[int];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_valid     = 1'b0;
        bus.i_ld_en     = 1'b0;
        bus.i_st_en     = 1'b0;
        bus.i_funct3    = 3'b000;
        bus.i_addr      = 32'h0;
        bus.i_st_data   = 32'h0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = 32'h0;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) $display("FAIL %s: got %0h expected %0h", name, got, want);
        else pass_cnt++;
    endtask

    // One transaction: drive the request, act as memory, then pop the scoreboard on o_done.
    task automatic do_txn(input string name, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] stdata, input int wait_k, input bit never_ack,
                          input logic [1:0] exp_err, input logic [31:0] exp_ld,
                          input int exp_lat, input int exp_req,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int          lat;
        int          reqs;
        bit          stable_ok;
        bit          done_seen;
        logic [31:0] w0;
        logic [3:0]  be0;
        logic [29:0] a0;
        exp_t        e;
        exp_q.push_back('{err: exp_err, ld: exp_ld});
        bus.i_valid   = 1'b1;
        bus.i_ld_en   = ld;
        bus.i_st_en   = st;
        bus.i_funct3  = f3;
        bus.i_addr    = addr;
        bus.i_st_data = stdata;
        #1;
        cmp({name, " busy_accept"}, 32'(bus.o_busy), 32'd1);
        tick();
        idle_inputs();
        lat = 1; reqs = 0; stable_ok = 1'b1; done_seen = 1'b0;
        w0 = '0; be0 = '0; a0 = '0;
        while (!done_seen && lat < 100) begin
            bus.i_mem_ack = 1'b0;
            if (bus.o_done) begin
                done_seen = 1'b1;
            end else begin
                if (bus.o_mem_req) begin
                    if (reqs == 0) begin
                        a0 = bus.o_mem_addr; be0 = bus.o_mem_be; w0 = bus.o_mem_wdata;
                        cmp({name, " mem_addr"}, 32'(bus.o_mem_addr), 32'(addr[31:2]));
                        cmp({name, " mem_be"}, 32'(bus.o_mem_be), 32'(exp_be));
                        cmp({name, " mem_we"}, 32'(bus.o_mem_we), 32'(st));
                        if (st) cmp({name, " mem_wdata"}, bus.o_mem_wdata, exp_wdata);
                    end else if (bus.o_mem_addr !== a0 || bus.o_mem_be !== be0 ||
                                 bus.o_mem_wdata !== w0) begin
                        stable_ok = 1'b0;
                    end
                    if (!bus.o_busy) stable_ok = 1'b0;
                    if (!never_ack && reqs == wait_k) begin
                        bus.i_mem_ack   = 1'b1;
                        bus.i_mem_rdata = mem.exists(int'(bus.o_mem_addr)) ?
                                          mem[int'(bus.o_mem_addr)] : 32'h0;
                        if (bus.o_mem_we) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.o_mem_be[b]) bus.i_mem_rdata[8*b +: 8] = bus.o_mem_wdata[8*b +: 8];
                            mem[int'(bus.o_mem_addr)] = bus.i_mem_rdata;
                        end
                    end
                    reqs++;
                end
                tick();
                lat++;
            end
        end
        if (!done_seen) begin
            total_cnt++;
            $display("FAIL %s done_timeout: no o_done within %0d cycles", name, lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            cmp({name, " err"}, 32'(bus.o_err), 32'(e.err));
            cmp({name, " ld_data"}, bus.o_ld_data, e.ld);
            cmp({name, " latency"}, 32'(lat), 32'(exp_lat));
            cmp({name, " req_cycles"}, 32'(reqs), 32'(exp_req));
            cmp({name, " stable"}, 32'(stable_ok), 32'd1);
            cmp({name, " busy_done"}, 32'(bus.o_busy), 32'd0);
            tick();
            cmp({name, " done_pulse"}, 32'(bus.o_done), 32'd0);
            cmp({name, " ld_hold"}, bus.o_ld_data, e.ld);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        cmp("rst busy", 32'(bus.o_busy), 32'd0);
        cmp("rst done", 32'(bus.o_done), 32'd0);
        cmp("rst ld_data", bus.o_ld_data, 32'd0);
        cmp("rst err", 32'(bus.o_err), 32'd0);
        cmp("rst req", 32'(bus.o_mem_req), 32'd0);
        cmp("rst we", 32'(bus.o_mem_we), 32'd0);
        cmp("rst addr", 32'(bus.o_mem_addr), 32'd0);
        cmp("rst be", 32'(bus.o_mem_be), 32'd0);
        cmp("rst wdata", bus.o_mem_wdata, 32'd0);
        rst = 1'b0;
        tick();
        bus.i_valid = 1'b1;
        #1;
        cmp("noop busy", 32'(bus.o_busy), 32'd0);
        tick();
        bus.i_valid = 1'b0;
        cmp("noop done", 32'(bus.o_done), 32'd0);
        cmp("noop req", 32'(bus.o_mem_req), 32'd0);
    endtask

    task automatic test_loads();
        mem[32'h1000 >> 2] = 32'h8899AABB;
        do_txn("LB",  1, 0, 3'b000, 32'h1002, 0, 0, 0, 2'b00, 32'hFFFFFF99, 2, 1, 4'b0100, 0);
        do_txn("LBU", 1, 0, 3'b100, 32'h1003, 0, 0, 0, 2'b00, 32'h00000088, 2, 1, 4'b1000, 0);
        do_txn("LH",  1, 0, 3'b001, 32'h1002, 0, 0, 0, 2'b00, 32'hFFFF8899, 2, 1, 4'b1100, 0);
        do_txn("LHU", 1, 0, 3'b101, 32'h1000, 0, 0, 0, 2'b00, 32'h0000AABB, 2, 1, 4'b0011, 0);
        do_txn("LW",  1, 0, 3'b010, 32'h1000, 0, 1, 0, 2'b00, 32'h8899AABB, 3, 2, 4'b1111, 0);
    endtask

    task automatic test_store_wait();
        do_txn("SB_wait", 0, 1, 3'b000, 32'h2001, 32'h12345678, 3, 0,
               2'b00, 32'h0, 5, 4, 4'b0010, 32'h78787878);
    endtask

    task automatic test_errors();
        do_txn("SH_misal", 0, 1, 3'b001, 32'h2003, 32'h1, 0, 0, 2'b01, 32'h0, 1, 0, 4'b0000, 0);
        do_txn("LW_misal", 1, 0, 3'b010, 32'h2002, 0, 0, 0, 2'b01, 32'h0, 1, 0, 4'b0000, 0);
        do_txn("LD_f3_011", 1, 0, 3'b011, 32'h2000, 0, 0, 0, 2'b10, 32'h0, 1, 0, 4'b0000, 0);
        do_txn("SBU_ill", 0, 1, 3'b100, 32'h2000, 0, 0, 0, 2'b10, 32'h0, 1, 0, 4'b0000, 0);
        do_txn("both_en", 1, 1, 3'b010, 32'h2000, 0, 0, 0, 2'b10, 32'h0, 1, 0, 4'b0000, 0);
    endtask

    task automatic test_timeout();
        do_txn("timeout", 1, 0, 3'b010, 32'h3000, 0, 0, 1, 2'b11, 32'h0, 17, 16, 4'b1111, 0);
    endtask

    task automatic test_back_to_back();
        do_txn("b2b_SW", 0, 1, 3'b010, 32'h4000, 32'hDEADBEEF, 0, 0,
               2'b00, 32'h0, 2, 1, 4'b1111, 32'hDEADBEEF);
        do_txn("b2b_SH", 0, 1, 3'b001, 32'h4006, 32'h1234CAFE, 0, 0,
               2'b00, 32'h0, 2, 1, 4'b1100, 32'hCAFECAFE);
        do_txn("b2b_LW0", 1, 0, 3'b010, 32'h4000, 0, 0, 0, 2'b00, 32'hDEADBEEF, 2, 1, 4'b1111, 0);
        do_txn("b2b_LW1", 1, 0, 3'b010, 32'h4004, 0, 2, 0, 2'b00, 32'hCAFE0000, 4, 3, 4'b1111, 0);
    endtask

    task automatic test_reset_mid();
        bus.i_valid  = 1'b1;
        bus.i_ld_en  = 1'b1;
        bus.i_funct3 = 3'b010;
        bus.i_addr   = 32'h3000;
        tick();
        idle_inputs();
        cmp("rmid req_n1", 32'(bus.o_mem_req), 32'd1);
        tick();
        cmp("rmid req_n2", 32'(bus.o_mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("rmid req_after", 32'(bus.o_mem_req), 32'd0);
        cmp("rmid no_done", 32'(bus.o_done), 32'd0);
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'hA5A5A5A5;
        tick();
        idle_inputs();
        cmp("late_ack done", 32'(bus.o_done), 32'd0);
        cmp("late_ack req", 32'(bus.o_mem_req), 32'd0);
        tick();
        cmp("late_ack done2", 32'(bus.o_done), 32'd0);
        cmp("late_ack ld_data", bus.o_ld_data, 32'd0);
        do_txn("post_rst_LW", 1, 0, 3'b010, 32'h1000, 0, 0, 0, 2'b00, 32'h8899AABB, 2, 1, 4'b1111, 0);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_wait();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        cmp("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
